// File: rtl/fetch_queue.sv
// Fetch stage: issues in-order instruction fetches at pc_i and buffers {pc, instr} for decode.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned PCs become NOP entries, no fetch).
module fetch_queue #(
    parameter int PC_Width = 32,
    parameter int INSTR_W  = 32,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_Width-1:0] pc_i,
    input  logic                flush_i,
    output logic                pc_advance_o,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_Width-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [PC_Width-1:0] id_pc,
    output logic [INSTR_W-1:0]  id_instr
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                id_misaligned
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);
    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013);

    logic [PC_Width-1:0] tag_mem    [DEPTH];
    logic [PC_Width-1:0] fifo_pc    [DEPTH];
    logic [INSTR_W-1:0]  fifo_instr [DEPTH];

    logic [AW-1:0] tag_wr;
    logic [AW-1:0] tag_rd;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    logic credit_ok;
    logic misaligned;
    logic mis_push;
    logic accept;
    logic rsp_keep;
    logic rsp_drop;
    logic push;
    logic pop;

    // A slot is free only when buffered entries plus in-flight requests leave room.
    assign credit_ok = ({1'b0, occupancy} + {1'b0, outstanding}) < CREDITS;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fifo_mis [DEPTH];

    assign misaligned = (pc_i[1:0] != 2'b00);
    // Bypass entries wait for the memory pipe to drain so the FIFO stays in program order.
    assign mis_push   = !rst && !flush_i && misaligned && credit_ok && (outstanding == '0);
`else
    assign misaligned = 1'b0;
    assign mis_push   = 1'b0;
`endif

    assign imem_req_valid = !rst && !flush_i && credit_ok && !misaligned;
    assign imem_req_addr  = pc_i;
    assign accept         = imem_req_valid && imem_req_ready;
    assign pc_advance_o   = accept || mis_push;

    assign rsp_keep = imem_rsp_valid && (drop == '0);
    assign rsp_drop = imem_rsp_valid && (drop != '0);

    assign id_valid = !rst && (occupancy != '0);
    assign id_pc    = fifo_pc[rd_ptr];
    assign id_instr = fifo_instr[rd_ptr];

`ifdef FETCH_MISALIGN_CHECK_EN
    assign id_misaligned = id_valid && fifo_mis[rd_ptr];
`endif

    // Responses landing in a flush cycle belong to the old path and are never buffered.
    assign push = !flush_i && (rsp_keep || mis_push);
    assign pop  = id_valid && id_ready && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr      <= '0;
            tag_rd      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            if (accept) begin
                tag_wr <= tag_wr + AW'(1);
            end
            if (imem_rsp_valid) begin
                tag_rd <= tag_rd + AW'(1);
            end
            outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);

            if (flush_i) begin
                // Everything still in flight after this cycle is stale.
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
                drop      <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                occupancy <= occupancy + CW'(push) - CW'(pop);
                if (rsp_drop) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    // Payload storage needs no reset; validity is carried by the counters above.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wr] <= pc_i;
        end
        if (push) begin
            fifo_pc[wr_ptr]    <= mis_push ? pc_i : tag_mem[tag_rd];
            fifo_instr[wr_ptr] <= mis_push ? NOP_INSTR : imem_rsp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
            fifo_mis[wr_ptr]   <= mis_push;
`endif
        end
    end

    rsp_needs_request: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding != '0));

    occupancy_bounded: assert property (@(posedge clk) disable iff (rst)
        occupancy <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: randomized memory/decode behaviour against a queue-based model.
module tb_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        pc_advance_o;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        id_misaligned;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.PC_Width(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .pc_i(pc_i),
        .flush_i(flush_i),
        .pc_advance_o(pc_advance_o),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_pc(id_pc),
        .id_instr(id_instr)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .id_misaligned(id_misaligned)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        int          due;
        bit          live;
    } req_t;

    // Memory-side view: every accepted request until its response returns.
    req_t        mem_q[$];
    // Decode-side view: PCs on the current path that decode must still see, oldest first.
    logic [31:0] exp_q[$];
    logic [31:0] delivered_q[$];
    int          buffered;
    int          cyc;
    int          checks;
    int          errors;

    bit          rst_now;
    bit          flush_now;
    logic [31:0] flush_pc;
    logic [31:0] cur_pc;
    int          ready_pct;
    int          idr_pct;
    int          lat_min;
    int          lat_max;

    logic        s_req_valid;
    logic        s_adv;
    logic        s_id_valid;
    logic [31:0] s_id_pc;
    logic [31:0] s_id_instr;
    logic [31:0] s_addr;
    bit          prev_stall;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // One clock of stimulus, model update and per-cycle rule checks.
    task automatic run_cycle();
        bit   rsp;
        bit   exp_req;
        bit   exp_idv;
        int   lat;
        req_t head;
        rst     = rst_now;
        flush_i = flush_now && !rst_now;
        if (flush_i) cur_pc = flush_pc;
        pc_i = cur_pc;
        rsp = !rst_now && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instr_of(mem_q[0].pc) : $urandom;
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        id_ready       = ($urandom_range(0, 99) < idr_pct);
        #1;
        s_req_valid = imem_req_valid;
        s_adv       = pc_advance_o;
        s_id_valid  = id_valid;
        s_id_pc     = id_pc;
        s_id_instr  = id_instr;
        s_addr      = imem_req_addr;

        exp_req = !rst_now && !flush_i && ((mem_q.size() + buffered) < DEPTH);
        exp_idv = !rst_now && (buffered > 0);

        checks++;
        if (s_req_valid !== exp_req) begin
            errors++;
            $display("[TB] FAIL req_valid cyc=%0d got=%b exp=%b", cyc, s_req_valid, exp_req);
        end
        checks++;
        if (s_adv !== (exp_req && imem_req_ready)) begin
            errors++;
            $display("[TB] FAIL pc_advance cyc=%0d got=%b exp=%b", cyc, s_adv, exp_req && imem_req_ready);
        end
        checks++;
        if (s_id_valid !== exp_idv) begin
            errors++;
            $display("[TB] FAIL id_valid cyc=%0d got=%b exp=%b", cyc, s_id_valid, exp_idv);
        end
        if (exp_req) begin
            checks++;
            if (s_addr !== cur_pc) begin
                errors++;
                $display("[TB] FAIL req_addr cyc=%0d got=%h exp=%h", cyc, s_addr, cur_pc);
            end
        end
        if (exp_idv) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL id_entry cyc=%0d got=%h exp=<none>", cyc, s_id_pc);
            end else if (s_id_pc !== exp_q[0] || s_id_instr !== instr_of(exp_q[0])) begin
                errors++;
                $display("[TB] FAIL id_entry cyc=%0d got=%h/%h exp=%h/%h", cyc, s_id_pc, s_id_instr,
                         exp_q[0], instr_of(exp_q[0]));
            end
        end
        if (prev_stall && exp_idv) begin
            checks++;
            if (s_id_pc !== prev_pc || s_id_instr !== prev_instr) begin
                errors++;
                $display("[TB] FAIL stall_hold cyc=%0d got=%h/%h exp=%h/%h", cyc, s_id_pc, s_id_instr,
                         prev_pc, prev_instr);
            end
        end

        if (rst_now) begin
            mem_q.delete();
            exp_q.delete();
            delivered_q.delete();
            buffered   = 0;
            prev_stall = 0;
        end else begin
            if (rsp) begin
                head = mem_q.pop_front();
                if (!flush_i && head.live) buffered++;
            end
            if (flush_i) begin
                buffered = 0;
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].live = 0;
            end else if (exp_idv && id_ready && exp_q.size() > 0) begin
                buffered--;
                delivered_q.push_back(exp_q.pop_front());
            end
            if (exp_req && imem_req_ready) begin
                lat = $urandom_range(lat_min, lat_max);
                mem_q.push_back('{cur_pc, cyc + lat, 1'b1});
                exp_q.push_back(cur_pc);
                cur_pc = cur_pc + 32'd4;
            end
            prev_stall = exp_idv && !id_ready && !flush_i;
            prev_pc    = s_id_pc;
            prev_instr = s_id_instr;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_now = 1; flush_now = 0; cur_pc = 32'h8000_0000;
        ready_pct = 100; idr_pct = 100; lat_min = 1; lat_max = 1;
        run_cycle();
        run_cycle();
        rst_now = 0;
        run_cycle();
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== 32'h8000_0000) begin
            errors++;
            $display("[TB] FAIL first_req got=%b/%h exp=1/80000000", s_req_valid, s_addr);
        end
        run_cycle();
        run_cycle();
        checks++;
        if (s_id_valid !== 1'b1 || s_id_pc !== 32'h8000_0000) begin
            errors++;
            $display("[TB] FAIL first_decode got=%b/%h exp=1/80000000", s_id_valid, s_id_pc);
        end
    endtask

    task automatic test_stream();
        int adv = 0;
        for (int i = 0; i < 16; i++) begin
            run_cycle();
            if (i >= 4 && s_adv === 1'b1) adv++;
        end
        checks++;
        if (adv < 7) begin
            errors++;
            $display("[TB] FAIL stream_rate got=%0d exp>=7", adv);
        end
        checks++;
        if (delivered_q.size() < 4) begin
            errors++;
            $display("[TB] FAIL stream_count got=%0d exp>=4", delivered_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (delivered_q[i] !== 32'h8000_0000 + 32'(4 * i)) begin
                    errors++;
                    $display("[TB] FAIL stream_order idx=%0d got=%h exp=%h", i, delivered_q[i],
                             32'h8000_0000 + 32'(4 * i));
                    break;
                end
            end
        end
    endtask

    task automatic test_stall();
        bit ok = 1;
        idr_pct = 0;
        for (int i = 0; i < 5; i++) run_cycle();
        checks++;
        if (s_id_valid !== 1'b1 || s_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_full got=%b/%b exp=1/0", s_id_valid, s_req_valid);
        end
        idr_pct = 100;
        for (int i = 0; i < 10; i++) run_cycle();
        checks++;
        foreach (delivered_q[i]) begin
            if (delivered_q[i] !== 32'h8000_0000 + 32'(4 * i)) ok = 0;
        end
        if (!ok || delivered_q.size() < 8) begin
            errors++;
            $display("[TB] FAIL stall_sequence got=%0d entries ok=%0d exp=consecutive", delivered_q.size(), ok);
        end
    endtask

    task automatic test_flush();
        int n = 0;
        lat_min = 3; lat_max = 3;
        while (mem_q.size() < 2 && n < 20) begin
            run_cycle();
            n++;
        end
        checks++;
        if (mem_q.size() < 2) begin
            errors++;
            $display("[TB] FAIL flush_setup got=%0d exp=2 outstanding", mem_q.size());
        end
        flush_now = 1; flush_pc = 32'h8000_0100;
        run_cycle();
        flush_now = 0;
        delivered_q.delete();
        n = 0;
        while (delivered_q.size() == 0 && n < 30) begin
            run_cycle();
            n++;
        end
        checks++;
        if (delivered_q.size() == 0 || delivered_q[0] !== 32'h8000_0100) begin
            errors++;
            $display("[TB] FAIL flush_target got=%0d entries exp=80000100 first", delivered_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        idr_pct = 0; ready_pct = 100; lat_min = 1; lat_max = 1;
        while (!(buffered == DEPTH && mem_q.size() == 0) && n < 20) begin
            run_cycle();
            n++;
        end
        checks++;
        if (buffered != DEPTH) begin
            errors++;
            $display("[TB] FAIL reset_mid_setup got=%0d exp=%0d buffered", buffered, DEPTH);
        end
        rst_now = 1; cur_pc = 32'h8000_0200;
        run_cycle();
        rst_now = 0; idr_pct = 100;
        run_cycle();
        checks++;
        if (s_id_valid !== 1'b0 || s_req_valid !== 1'b1 || s_addr !== 32'h8000_0200) begin
            errors++;
            $display("[TB] FAIL reset_mid got=%b/%b/%h exp=0/1/80000200", s_id_valid, s_req_valid, s_addr);
        end
    endtask

    task automatic test_random();
        ready_pct = 75; idr_pct = 65; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            flush_now = ($urandom_range(0, 99) < 4);
            flush_pc  = 32'h8000_0000 + 32'($urandom_range(0, 1023) * 4);
            run_cycle();
        end
        flush_now = 0;
    endtask

`ifdef FETCH_MISALIGN_CHECK_EN
    task automatic test_misaligned();
        rst_now = 1;
        run_cycle();
        rst_now = 0;
        rst = 0; flush_i = 0; imem_rsp_valid = 0; id_ready = 0;
        imem_req_ready = 1; pc_i = 32'h8000_0002;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misaligned_req got=%b exp=0", imem_req_valid);
        end
        @(posedge clk);
        #1;
        imem_req_ready = 0;
        #1;
        checks++;
        if (id_valid !== 1'b1 || id_misaligned !== 1'b1 || id_instr !== 32'h0000_0013 || id_pc !== 32'h8000_0002) begin
            errors++;
            $display("[TB] FAIL misaligned_entry got=%b/%b/%h/%h exp=1/1/00000013/80000002",
                     id_valid, id_misaligned, id_instr, id_pc);
        end
        @(posedge clk);
        #1;
        rst_now = 1;
        run_cycle();
        rst_now = 0;
    endtask
`endif

    initial begin
        checks = 0; errors = 0; cyc = 0; buffered = 0; prev_stall = 0;
        rst = 1; flush_i = 0; pc_i = 32'h8000_0000; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = '0; id_ready = 0;
        rst_now = 1; flush_now = 0; flush_pc = '0; cur_pc = 32'h8000_0000;
        ready_pct = 100; idr_pct = 100; lat_min = 1; lat_max = 1;
        prev_pc = '0; prev_instr = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef FETCH_MISALIGN_CHECK_EN
        test_misaligned();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
